// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// The same-cycle read bypass is enabled with the REGFILE_BYPASS_EN macro.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rfState_t;

    localparam int MAX_NUM_RD = 4;
    localparam int MAX_NUM_WR = 2;

    // A byte takes the new value only when its enable is set.
    function automatic logic [7:0] mergeByte(
        input logic [7:0] oldByte,
        input logic [7:0] newByte,
        input logic       en
    );
        return en ? newByte : oldByte;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read-port mux: stored entry, optional write bypass
// (REGFILE_BYPASS_EN), then zero forcing for entry 0 and the clear sweep.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
`ifdef REGFILE_BYPASS_EN
    parameter int NUM_WR   = 1,
`endif
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]        rdAddr,
    input  logic [DATA_W-1:0]        entryData,
    input  logic                     isClearing,
`ifdef REGFILE_BYPASS_EN
    input  logic [NUM_WR-1:0]        wrAccept,
    input  logic [NUM_WR*ADDR_W-1:0] wrAddr,
    input  logic [NUM_WR*DATA_W-1:0] wrData,
    input  logic [NUM_WR*DATA_W/8-1:0] wrBe,
`endif
    output logic [DATA_W-1:0]        rdData
);

    localparam int NB = DATA_W / 8;

    always_comb begin
        rdData = entryData;
`ifdef REGFILE_BYPASS_EN
        // Walk ports in ascending order so the higher port wins per byte.
        for (int w = 0; w < NUM_WR; w++) begin
            if (wrAccept[w] && (wrAddr[w*ADDR_W +: ADDR_W] == rdAddr)) begin
                for (int b = 0; b < NB; b++) begin
                    rdData[b*8 +: 8] = mergeByte(rdData[b*8 +: 8],
                                                 wrData[w*DATA_W + b*8 +: 8],
                                                 wrBe[w*NB + b]);
                end
            end
        end
`endif
        if (isClearing || ((ZERO_REG != 0) && (rdAddr == '0))) begin
            rdData = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised NUM_RD-read / NUM_WR-write register file with byte enables and
// a one-entry-per-cycle clear sweep. Optional bypass: REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    output logic                       ready,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic [NUM_WR*DATA_W/8-1:0] wr_be
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    rfState_t          stateReg, stateNext;
    logic [ADDR_W-1:0] sweepReg, sweepNext;
    logic [NUM_WR-1:0] wrAccept;
    logic [DATA_W-1:0] regArray [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateReg <= CLEAR;
            sweepReg <= '0;
        end else begin
            stateReg <= stateNext;
            sweepReg <= sweepNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        sweepNext = sweepReg;
        case (stateReg)
            CLEAR: begin
                sweepNext = sweepReg + 1'b1;
                if (sweepReg == '1) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (clear) begin
                    stateNext = CLEAR;
                    sweepNext = '0;
                end
            end
            default: begin
                stateNext = CLEAR;
                sweepNext = '0;
            end
        endcase
    end

    assign ready = (stateReg == RUN);

    // A clear request in the same cycle drops every write.
    generate
        for (genvar gi = 0; gi < NUM_WR; gi++) begin : gWrAccept
            assign wrAccept[gi] = wr_en[gi] && (stateReg == RUN) && !clear &&
                                  !((ZERO_REG != 0) && (wr_addr[gi*ADDR_W +: ADDR_W] == '0));
        end
    endgenerate

    // Storage has no reset so it can map onto distributed RAM; later ports'
    // assignments land last and therefore win per byte.
    always_ff @(posedge clock) begin
        if (stateReg == CLEAR) begin
            regArray[sweepReg] <= '0;
        end
        for (int w = 0; w < NUM_WR; w++) begin
            for (int b = 0; b < NB; b++) begin
                if (wrAccept[w] && wr_be[w*NB + b]) begin
                    regArray[wr_addr[w*ADDR_W +: ADDR_W]][b*8 +: 8] <= wr_data[w*DATA_W + b*8 +: 8];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : gRdPort
            regfile_rd_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
`ifdef REGFILE_BYPASS_EN
                .NUM_WR   (NUM_WR),
`endif
                .ZERO_REG (ZERO_REG)
            ) uRdPort (
                .rdAddr     (rd_addr[gi*ADDR_W +: ADDR_W]),
                .entryData  (regArray[rd_addr[gi*ADDR_W +: ADDR_W]]),
                .isClearing (stateReg == CLEAR),
`ifdef REGFILE_BYPASS_EN
                .wrAccept   (wrAccept),
                .wrAddr     (wr_addr),
                .wrData     (wr_data),
                .wrBe       (wr_be),
`endif
                .rdData     (rd_data[gi*DATA_W +: DATA_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench: a 2R2W ZERO_REG=1 file and a 1R1W ZERO_REG=0 file.
`timescale 1ns/1ps
module tb_regfile_mp;

    logic        clock;
    logic        reset;

    logic        clear0, ready0;
    logic [9:0]  rdAddr0;
    logic [63:0] rdData0;
    logic [1:0]  wrEn0;
    logic [9:0]  wrAddr0;
    logic [63:0] wrData0;
    logic [7:0]  wrBe0;

    logic        clear1, ready1;
    logic [2:0]  rdAddr1;
    logic [31:0] rdData1;
    logic [0:0]  wrEn1;
    logic [2:0]  wrAddr1;
    logic [31:0] wrData1;
    logic [3:0]  wrBe1;

    int nVec  = 0;
    int nMiss = 0;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut0 (
        .clock(clock), .reset(reset), .clear(clear0), .ready(ready0),
        .rd_addr(rdAddr0), .rd_data(rdData0), .wr_en(wrEn0),
        .wr_addr(wrAddr0), .wr_data(wrData0), .wr_be(wrBe0)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(3), .NUM_RD(1), .NUM_WR(1), .ZERO_REG(0)) dut1 (
        .clock(clock), .reset(reset), .clear(clear1), .ready(ready1),
        .rd_addr(rdAddr1), .rd_data(rdData1), .wr_en(wrEn1),
        .wr_addr(wrAddr1), .wr_data(wrData1), .wr_be(wrBe1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        if (obs !== exp) begin
            nMiss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic setWr0(input int p, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        wrEn0[p]            = 1'b1;
        wrAddr0[p*5 +: 5]   = a;
        wrData0[p*32 +: 32] = d;
        wrBe0[p*4 +: 4]     = be;
    endtask

    task automatic rd0(input int p, input logic [4:0] a, input string tag, input logic [31:0] exp);
        rdAddr0[p*5 +: 5] = a;
        #1;
        chk(tag, rdData0[p*32 +: 32], exp);
    endtask

    logic [31:0] expBypass;

    initial begin
        reset = 1'b0;
        clear0 = 1'b0; rdAddr0 = '0; wrEn0 = '0; wrAddr0 = '0; wrData0 = '0; wrBe0 = '0;
        clear1 = 1'b0; rdAddr1 = '0; wrEn1 = '0; wrAddr1 = '0; wrData1 = '0; wrBe1 = '0;
        step(); step();
        chk("reset_ready", {31'b0, ready0}, 32'h0);
        rd0(0, 5'd5, "reset_rd", 32'h0);
        reset = 1'b1;

        // Sweep after reset: DEPTH edges before ready rises.
        for (int i = 1; i <= 32; i++) begin
            step();
            if (i == 7)  chk("dut1_ready_e7", {31'b0, ready1}, 32'h0);
            if (i == 8)  chk("dut1_ready_e8", {31'b0, ready1}, 32'h1);
            if (i == 31) chk("ready_e31", {31'b0, ready0}, 32'h0);
            if (i == 32) chk("ready_e32", {31'b0, ready0}, 32'h1);
        end
        for (int a = 0; a < 32; a += 3) begin
            rd0(0, 5'(a), $sformatf("zero_p0_r%0d", a), 32'h0);
            rd0(1, 5'(31 - a), $sformatf("zero_p1_r%0d", 31 - a), 32'h0);
        end

        // Byte-enable partial write.
        setWr0(0, 5'd5, 32'hDEADBEEF, 4'b1111); step();
        setWr0(0, 5'd5, 32'h00000011, 4'b0001); step();
        wrEn0 = '0;
        rd0(0, 5'd5, "be_partial_r5", 32'hDEADBE11);
        setWr0(0, 5'd5, 32'h00000000, 4'b0000); step();
        wrEn0 = '0;
        rd0(1, 5'd5, "be_zero_noop", 32'hDEADBE11);

        // Two ports on the same address.
        setWr0(0, 5'd7, 32'h11111111, 4'b1111);
        setWr0(1, 5'd7, 32'h22222222, 4'b1111); step();
        wrEn0 = '0;
        rd0(0, 5'd7, "conflict_full", 32'h22222222);
        setWr0(0, 5'd7, 32'h11111111, 4'b1100);
        setWr0(1, 5'd7, 32'h22222222, 4'b0011); step();
        wrEn0 = '0;
        rd0(0, 5'd7, "conflict_split", 32'h11112222);
        setWr0(0, 5'd7, 32'hAAAAAAAA, 4'b1110);
        setWr0(1, 5'd7, 32'hBBBBBBBB, 4'b0110); step();
        wrEn0 = '0;
        rd0(1, 5'd7, "conflict_overlap", 32'hAABBBB22);

        // Entry 0 with and without the hardwired zero; highest address on dut1.
        setWr0(1, 5'd0, 32'hFFFFFFFF, 4'b1111);
        wrEn1 = 1'b1; wrAddr1 = 3'd0; wrData1 = 32'hFFFFFFFF; wrBe1 = 4'hF;
        step();
        wrEn0 = '0;
        wrAddr1 = 3'd7; wrData1 = 32'h01020304; step();
        wrEn1 = '0;
        rd0(0, 5'd0, "zero_reg_r0", 32'h0);
        rdAddr1 = 3'd0; #1;
        chk("nozero_r0", rdData1, 32'hFFFFFFFF);
        rdAddr1 = 3'd7; #1;
        chk("dut1_r7", rdData1, 32'h01020304);

        // Same-cycle read of the address being written.
`ifdef REGFILE_BYPASS_EN
        expBypass = 32'hA5A5A5A5;
`else
        expBypass = 32'h00000000;
`endif
        setWr0(0, 5'd3, 32'hA5A5A5A5, 4'b1111);
        rd0(1, 5'd3, "same_cycle_r3", expBypass);
        step();
        wrEn0 = '0;
        rd0(1, 5'd3, "after_write_r3", 32'hA5A5A5A5);

        // Clear pulse with a concurrent write, then reset mid-sweep.
        clear0 = 1'b1;
        setWr0(0, 5'd9, 32'h12345678, 4'b1111);
        step();
        clear0 = 1'b0; wrEn0 = '0;
        chk("clear_ready", {31'b0, ready0}, 32'h0);
        rd0(0, 5'd5, "clear_rd_forced", 32'h0);
        for (int i = 0; i < 10; i++) step();
        chk("sweep10_ready", {31'b0, ready0}, 32'h0);
        reset = 1'b0;
        #2;
        chk("reset_mid_ready", {31'b0, ready0}, 32'h0);
        reset = 1'b1;

        // Writes and clear during the sweep must be ignored.
        for (int i = 1; i <= 32; i++) begin
            if (i == 10) setWr0(0, 5'd2, 32'hDEAD0002, 4'b1111);
            if (i == 20) clear0 = 1'b1;
            step();
            wrEn0 = '0; clear0 = 1'b0;
            if (i == 31) chk("resweep_ready_e31", {31'b0, ready0}, 32'h0);
            if (i == 32) chk("resweep_ready_e32", {31'b0, ready0}, 32'h1);
        end
        rd0(0, 5'd9, "post_r9", 32'h0);
        rd0(1, 5'd5, "post_r5", 32'h0);
        rd0(0, 5'd7, "post_r7", 32'h0);
        rd0(1, 5'd3, "post_r3", 32'h0);
        rd0(0, 5'd2, "post_r2_sweep_write", 32'h0);
        rd0(1, 5'd31, "post_r31", 32'h0);
        rdAddr1 = 3'd0; #1;
        chk("dut1_post_r0", rdData1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the MIPS32 core family and its successors. Provides NUM_RD combinational read ports, NUM_WR synchronous write ports with byte enables, an optional hardwired-zero entry 0, and a hardware clear sequencer. Storage has no per-entry reset, so it can map to distributed RAM; contents are zeroed by a one-entry-per-cycle sweep instead. Sits in the decode/ID stage in place of the fixed 2R1W file.

## Interface
- DATA_W, 32, register width in bits; multiple of 8
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, read ports, 1..4
- NUM_WR, 1, write ports, 1..2
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes
- clock  in  1  clock, all state on rising edge
- reset  in  1  asynchronous active-low reset
- clear  in  1  request to zero every entry (sampled in RUN only)
- ready  out  1  high when in RUN; writes accepted only when high
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port p at [p*DATA_W +: DATA_W]
- wr_en  in  NUM_WR  write enable per port
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- wr_be  in  NUM_WR*DATA_W/8  byte enables; only enabled bytes change

## Operation
- FSM states CLEAR, RUN. Reset asserted: state=CLEAR, sweep counter=0, ready=0.
- CLEAR: each edge writes 0 to entry[counter], counter+1. Edge where counter==DEPTH-1 moves to RUN. Writes ignored; all rd_data = 0.
- RUN: ready=1. clear=1 at an edge: state=CLEAR, counter=0; writes in that cycle dropped (clear wins). clear during CLEAR ignored (no restart).
- Write: port w commits at edge when wr_en[w]=1, state=RUN, and not (ZERO_REG and wr_addr==0). Bytes with wr_be=0 keep old value; wr_be all-zero is a no-op.
- Same-address conflict between ports: higher-indexed port wins per byte where both enabled; bytes enabled only on the lower port take the lower port's data.
- Read: rd_data[p] = 0 if ZERO_REG and rd_addr[p]==0; else entry[rd_addr[p]] (plus bypass, see Configuration). Any port may read any address, including the same one.
- Reset mid-sweep or mid-RUN: restarts sweep from entry 0; prior contents undefined until sweep completes.

## Timing
- Reset values: ready=0; rd_data=0 (forced by CLEAR state).
- Reads combinational, zero latency. Writes visible at the next cycle's read (or same cycle with bypass).
- After reset deassert: DEPTH edges of sweep; ready rises after edge DEPTH (32 edges for ADDR_W=5).
- clear pulse in RUN: ready low from the following cycle for DEPTH cycles, then high.

## Configuration
- REGFILE_BYPASS_EN defined: read port whose address matches an active, accepted write in the same cycle returns the merged post-write value (per-byte, same priority as the commit; old bytes where not enabled). ZERO_REG still forces 0.
- Not defined: reads return pre-write contents; new value appears the cycle after the edge.

## Structure
- regfile_pkg: state enum typedef (CLEAR, RUN), helper function for byte-merge of old/new data by byte enable, constant for max NUM_RD/NUM_WR.
- Sub-module regfile_rd_port: one read-port mux (zero-reg force, CLEAR force, optional bypass), generated NUM_RD times.

## Test plan
- Reset release, default params -> ready=0 for 32 cycles, then 1; every address reads 0x00000000.
- Write 0xDEADBEEF to r5, wr_be=4'b1111; next cycle write 0x00000011 to r5, wr_be=4'b0001 -> r5 reads 0xDEADBE11.
- NUM_WR=2, both ports write r7 (port0 0x11111111, port1 0x22222222, be all ones) -> r7 reads 0x22222222; port0 be=4'b1100, port1 be=4'b0011 -> r7 reads 0x11112222.
- Write 0xFFFFFFFF to r0 with ZERO_REG=1 -> r0 reads 0; with ZERO_REG=0 -> reads 0xFFFFFFFF.
- Write r3=0xA5A5A5A5 while reading r3 same cycle -> read 0xA5A5A5A5 with REGFILE_BYPASS_EN, old value without.
- clear pulse with a concurrent write to r9, then reset asserted at sweep entry 10 -> write dropped, sweep restarts, ready high 32 cycles after reset release, all entries 0.
